object_marker_sprite: RTL and testbench
=======================================

// Module: object_marker_sprite
// PURPOSE
// Consumes on-screen pixel coordinates (pixel_x 11b, pixel_y 10b) from the mm-to-pixel scaler and draws a square marker in the XVGA 1024x768 raster.
// - New coordinates are captured as they arrive but committed only at frame start (vsync falling edge), so the marker never tears mid-frame.
// - Tracks the age of the committed position: a fresh marker is drawn in COLOR, a stale one in STALE_COLOR, and an expired one is hidden.
// - Output pixel feeds the display mixer.
// PARAMETERS
// HALF         4          marker half-width in pixels; square is (2*HALF+1)^2
// COLOR        24'hFF0000 RGB for LIVE marker
// STALE_COLOR  24'h808080 RGB for STALE marker
// STALE_FRAMES 30         frames without a commit before LIVE->STALE (1..254)
// HIDE_FRAMES  120        frames without a commit before ->HIDDEN (>STALE_FRAMES, <=255)
// PORTS
// clk         in   1   pixel clock (65 MHz XVGA clock)
// reset       in   1   asynchronous, active-high reset
// hcount      in   11  raster x, 0..1343
// vcount      in   10  raster y, 0..805
// vsync       in   1   active-low vertical sync from the XVGA timing generator
// blank       in   1   high outside the active area
// coord_valid in   1   one-cycle strobe: obj_x/obj_y hold a new position
// obj_x       in   11  marker centre x, in pixels
// obj_y       in   10  marker centre y, in pixels
// pixel       out  24  RGB output; 0 when no marker is present at that pixel
// marker_on   out  1   high when the marker covers the delayed pixel
// stale       out  1   high while in the STALE state
// BEHAVIOUR
// - Reset (async, active-high) forces:
//   - pixel=0, marker_on=0, stale=0
//   - state=HIDDEN, age=0, pend_valid=0
//   - pending/committed centre=0, vsync_d=1
// - frame_tick: one-cycle pulse when vsync_d=1 and vsync=0 (registered vsync, falling edge).
// - Capture: coord_valid=1 loads pend_x/pend_y from obj_x/obj_y and sets pend_valid. A later strobe in the same frame overwrites (last wins).
// - Commit on frame_tick with pend_valid=1, or with coord_valid=1 in the same cycle (the input value wins over the pending value):
//   - cx/cy <= the committed value; pend_valid <= 0; age <= 0; state <= LIVE.
// - State machine, advancing only on frame_tick without a commit:
//   - HIDDEN: stays HIDDEN; age holds at 0.
//   - LIVE: age+1; if age+1 == STALE_FRAMES -> STALE.
//   - STALE: age+1; if age+1 == HIDE_FRAMES -> HIDDEN, age <= 0.
//   - A commit from any state -> LIVE, age 0.
// - Hit test, in signed 13-bit arithmetic:
//   - dx = hcount-cx, dy = vcount-cy.
//   - hit = |dx|<=HALF and |dy|<=HALF and cx<1024 and cy<768.
//   - Edges clip naturally (e.g. cx=0 draws columns 0..HALF only; there is no wrap to column 1343).
//   - Off-screen centres (cx>=1024 or cy>=768, e.g. an underflowed scaler y) commit and age normally but never draw.
// - Pipeline, fixed latency of 2 clocks from hcount/vcount/blank to pixel/marker_on:
//   - S1 registers hit and blank.
//   - S2 registers marker_on = hit_d & ~blank_d & (state!=HIDDEN).
//   - S2 also registers pixel = marker_on ? (state==STALE ? STALE_COLOR : COLOR) : 0.
//   - The caller delays hsync/vsync/blank by 2 clocks to align.
// - stale is registered with state and is updated in the cycle after frame_tick.
// - Mid-frame coord_valid never changes cx/cy before the next frame_tick.
// TESTING
// - Reset mid-frame, with state LIVE -> next cycle pixel=0, marker_on=0, stale=0; no marker drawn in later frames until a new commit.
// - coord_valid with (512,384), then frame_tick -> that frame: marker_on=1 exactly for hcount 508..516, vcount 380..388; pixel=FF0000 there, 0 elsewhere; 2-clock latency checked at hcount=508.
// - Strobes (100,100) then (200,200) in one frame -> next frame only (200,200) drawn. coord_valid=(300,300) coincident with frame_tick -> (300,300) drawn immediately.
// - Commit (0,0) -> drawn region is hcount 0..4, vcount 0..4 only; commit (700,900) -> marker_on never asserts.
// - Commit once, then 30 frame_ticks -> stale=1, pixel=808080; after 120 ticks total -> marker hidden. A new commit at tick 125 -> LIVE, FF0000.
// - Strobe while blank=1 at the hit location -> pixel=0 during blank; commit still occurs at the next frame_tick.

Source files
------------

// File: rtl/object_marker_sprite.sv
// rtl/object_marker_sprite.sv - square position marker overlay for the 1024x768 raster
//
// Draws a (2*HALF+1)^2 square centred on the last committed object position.
// New positions are buffered and committed only at frame start (vsync falling
// edge), so the marker never tears. The committed position ages frame by frame:
// LIVE draws COLOR, STALE draws STALE_COLOR, HIDDEN draws nothing.
//
// Ports:
//   clk_i          pixel clock
//   reset_i        asynchronous active-high reset
//   hcount_i[10:0] raster x
//   vcount_i[9:0]  raster y
//   vsync_i        active-low vertical sync
//   blank_i        high outside the active area
//   coord_valid_i  strobe: obj_x_i/obj_y_i carry a new position
//   obj_x_i[10:0]  marker centre x
//   obj_y_i[9:0]   marker centre y
//   pixel_o[23:0]  RGB, 0 where no marker (2 clocks after hcount/vcount/blank)
//   marker_on_o    marker covers the delayed pixel
//   stale_o        marker is in the STALE state
module object_marker_sprite #(
  parameter int unsigned  HALF         = 4,
  parameter logic [23:0]  COLOR        = 24'hFF0000,
  parameter logic [23:0]  STALE_COLOR  = 24'h808080,
  parameter int unsigned  STALE_FRAMES = 30,
  parameter int unsigned  HIDE_FRAMES  = 120
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [10:0] hcount_i,
  input  logic [9:0]  vcount_i,
  input  logic        vsync_i,
  input  logic        blank_i,
  input  logic        coord_valid_i,
  input  logic [10:0] obj_x_i,
  input  logic [9:0]  obj_y_i,
  output logic [23:0] pixel_o,
  output logic        marker_on_o,
  output logic        stale_o
);

  typedef enum logic [1:0] {
    ST_HIDDEN = 2'd0,
    ST_LIVE   = 2'd1,
    ST_STALE  = 2'd2
  } state_t;

  localparam logic [7:0]         STALE_LIM = 8'(STALE_FRAMES);
  localparam logic [7:0]         HIDE_LIM  = 8'(HIDE_FRAMES);
  localparam logic signed [12:0] HALF_S    = 13'(HALF);

  state_t      state_q, state_d;
  logic [7:0]  age_q, age_d;
  logic        vsync_d_q;
  logic        pend_valid_q;
  logic [10:0] pend_x_q, cx_q;
  logic [9:0]  pend_y_q, cy_q;
  logic        hit_q, blank_q;
  logic        marker_on_q, stale_q;
  logic [23:0] pixel_q;

  logic        frame_tick;
  logic        commit;
  logic [7:0]  age_inc;

  assign frame_tick = vsync_d_q & ~vsync_i;
  // A strobe coincident with the frame tick commits directly, bypassing pend.
  assign commit     = frame_tick & (pend_valid_q | coord_valid_i);
  assign age_inc    = age_q + 8'd1;

  always_comb begin
    state_d = state_q;
    age_d   = age_q;
    if (commit) begin
      state_d = ST_LIVE;
      age_d   = 8'd0;
    end else if (frame_tick) begin
      case (state_q)
        ST_LIVE: begin
          age_d = age_inc;
          if (age_inc == STALE_LIM) state_d = ST_STALE;
        end
        ST_STALE: begin
          age_d = age_inc;
          if (age_inc == HIDE_LIM) begin
            state_d = ST_HIDDEN;
            age_d   = 8'd0;
          end
        end
        default: begin
          state_d = ST_HIDDEN;
          age_d   = 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_HIDDEN;
      age_q   <= 8'd0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      age_q   <= age_d;
      stale_q <= (state_d == ST_STALE);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      vsync_d_q    <= 1'b1;
      pend_valid_q <= 1'b0;
      pend_x_q     <= 11'd0;
      pend_y_q     <= 10'd0;
      cx_q         <= 11'd0;
      cy_q         <= 10'd0;
    end else begin
      vsync_d_q <= vsync_i;
      if (commit) begin
        cx_q         <= coord_valid_i ? obj_x_i : pend_x_q;
        cy_q         <= coord_valid_i ? obj_y_i : pend_y_q;
        pend_valid_q <= 1'b0;
      end else if (coord_valid_i) begin
        pend_x_q     <= obj_x_i;
        pend_y_q     <= obj_y_i;
        pend_valid_q <= 1'b1;
      end
    end
  end

  // Zero-extended operands keep the subtraction signed without wrap at edges.
  logic signed [12:0] dx_s, dy_s;
  logic               hit;

  assign dx_s = $signed({2'b00, hcount_i}) - $signed({2'b00, cx_q});
  assign dy_s = $signed({3'b000, vcount_i}) - $signed({3'b000, cy_q});
  assign hit  = (dx_s >= -HALF_S) && (dx_s <= HALF_S) &&
                (dy_s >= -HALF_S) && (dy_s <= HALF_S) &&
                (cx_q < 11'd1024) && (cy_q < 10'd768);

  logic on_d;
  assign on_d = hit_q & ~blank_q & (state_q != ST_HIDDEN);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hit_q       <= 1'b0;
      blank_q     <= 1'b1;
      marker_on_q <= 1'b0;
      pixel_q     <= 24'd0;
    end else begin
      hit_q       <= hit;
      blank_q     <= blank_i;
      marker_on_q <= on_d;
      pixel_q     <= on_d ? ((state_q == ST_STALE) ? STALE_COLOR : COLOR) : 24'd0;
    end
  end

  assign pixel_o     = pixel_q;
  assign marker_on_o = marker_on_q;
  assign stale_o     = stale_q;

endmodule

// File: tb/tb_object_marker_sprite.sv
// tb/tb_object_marker_sprite.sv - directed bench for object_marker_sprite
module tb_object_marker_sprite;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic [10:0] hcount_i = '0;
  logic [9:0]  vcount_i = '0;
  logic        vsync_i = 1'b1;
  logic        blank_i = 1'b0;
  logic        coord_valid_i = 1'b0;
  logic [10:0] obj_x_i = '0;
  logic [9:0]  obj_y_i = '0;
  logic [23:0] pixel_o;
  logic        marker_on_o;
  logic        stale_o;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [23:0] RED  = 24'hFF0000;
  localparam logic [23:0] GREY = 24'h808080;

  object_marker_sprite dut (
    .clk_i(clk_i), .reset_i(reset_i), .hcount_i(hcount_i), .vcount_i(vcount_i),
    .vsync_i(vsync_i), .blank_i(blank_i), .coord_valid_i(coord_valid_i),
    .obj_x_i(obj_x_i), .obj_y_i(obj_y_i), .pixel_o(pixel_o),
    .marker_on_o(marker_on_o), .stale_o(stale_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic frame_tick();
    @(negedge clk_i); vsync_i = 1'b0;
    @(negedge clk_i); vsync_i = 1'b1;
    @(negedge clk_i);
  endtask

  task automatic strobe(input logic [10:0] x, input logic [9:0] y);
    @(negedge clk_i); coord_valid_i = 1'b1; obj_x_i = x; obj_y_i = y;
    @(negedge clk_i); coord_valid_i = 1'b0;
  endtask

  // Drives a raster position and checks the outputs two clocks later.
  task automatic probe(input string tag, input int h, input int v, input logic b,
                       input logic exp_on, input logic [23:0] exp_px);
    @(negedge clk_i); hcount_i = 11'(h); vcount_i = 10'(v); blank_i = b;
    @(posedge clk_i); @(posedge clk_i); #1;
    check_eq({tag, "_on"}, {31'd0, marker_on_o}, {31'd0, exp_on});
    check_eq({tag, "_px"}, {8'd0, pixel_o}, {8'd0, exp_px});
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    check_eq("rst_px", {8'd0, pixel_o}, 32'd0);
    check_eq("rst_on", {31'd0, marker_on_o}, 32'd0);
    check_eq("rst_stale", {31'd0, stale_o}, 32'd0);
    reset_i = 1'b0;
    frame_tick();
    probe("hidden_origin", 0, 0, 1'b0, 1'b0, 24'd0);

    // Centre (512,384): row and column sweep through the edges
    strobe(11'd512, 10'd384);
    probe("precommit", 512, 384, 1'b0, 1'b0, 24'd0);
    frame_tick();
    for (int h = 505; h <= 519; h++)
      probe($sformatf("row_h%0d", h), h, 384, 1'b0,
            (h >= 508 && h <= 516), (h >= 508 && h <= 516) ? RED : 24'd0);
    for (int v = 378; v <= 390; v++)
      probe($sformatf("col_v%0d", v), 512, v, 1'b0,
            (v >= 380 && v <= 388), (v >= 380 && v <= 388) ? RED : 24'd0);
    probe("corner_tl", 508, 380, 1'b0, 1'b1, RED);
    probe("corner_br", 516, 388, 1'b0, 1'b1, RED);
    probe("diag_out", 507, 379, 1'b0, 1'b0, 24'd0);

    // Two-clock latency at hcount=508
    probe("lat_pre", 0, 384, 1'b0, 1'b0, 24'd0);
    @(negedge clk_i); hcount_i = 11'd508;
    @(posedge clk_i); #1;
    check_eq("lat_1clk", {31'd0, marker_on_o}, 32'd0);
    @(posedge clk_i); #1;
    check_eq("lat_2clk", {31'd0, marker_on_o}, 32'd1);
    check_eq("lat_2clk_px", {8'd0, pixel_o}, {8'd0, RED});

    // Last strobe wins
    strobe(11'd100, 10'd100);
    strobe(11'd200, 10'd200);
    probe("midframe_hold", 512, 384, 1'b0, 1'b1, RED);
    frame_tick();
    probe("lw_100", 100, 100, 1'b0, 1'b0, 24'd0);
    probe("lw_200", 200, 200, 1'b0, 1'b1, RED);
    probe("lw_196", 196, 200, 1'b0, 1'b1, RED);
    probe("lw_195", 195, 200, 1'b0, 1'b0, 24'd0);

    // Strobe coincident with the frame tick commits at once
    @(negedge clk_i); vsync_i = 1'b0; coord_valid_i = 1'b1; obj_x_i = 11'd300; obj_y_i = 10'd300;
    @(negedge clk_i); vsync_i = 1'b1; coord_valid_i = 1'b0;
    probe("coin_300", 300, 300, 1'b0, 1'b1, RED);
    probe("coin_200", 200, 200, 1'b0, 1'b0, 24'd0);

    // Clipping at the origin
    strobe(11'd0, 10'd0);
    frame_tick();
    probe("clip_00", 0, 0, 1'b0, 1'b1, RED);
    probe("clip_44", 4, 4, 1'b0, 1'b1, RED);
    probe("clip_50", 5, 0, 1'b0, 1'b0, 24'd0);
    probe("clip_05", 0, 5, 1'b0, 1'b0, 24'd0);
    probe("clip_wrapx", 1343, 0, 1'b0, 1'b0, 24'd0);
    probe("clip_wrapy", 0, 805, 1'b0, 1'b0, 24'd0);

    // Off-screen centre never draws
    strobe(11'd700, 10'd900);
    frame_tick();
    probe("off_767", 700, 767, 1'b0, 1'b0, 24'd0);
    probe("off_900", 700, 900, 1'b0, 1'b0, 24'd0);
    probe("off_896", 700, 896, 1'b0, 1'b0, 24'd0);
    check_eq("off_stale", {31'd0, stale_o}, 32'd0);

    // Aging: commit, then 29 ticks LIVE, 30th STALE, 120th HIDDEN
    strobe(11'd512, 10'd384);
    frame_tick();
    repeat (29) frame_tick();
    check_eq("age29_stale", {31'd0, stale_o}, 32'd0);
    probe("age29", 512, 384, 1'b0, 1'b1, RED);
    frame_tick();
    check_eq("age30_stale", {31'd0, stale_o}, 32'd1);
    probe("age30", 512, 384, 1'b0, 1'b1, GREY);
    repeat (89) frame_tick();
    check_eq("age119_stale", {31'd0, stale_o}, 32'd1);
    probe("age119", 512, 384, 1'b0, 1'b1, GREY);
    frame_tick();
    check_eq("age120_stale", {31'd0, stale_o}, 32'd0);
    probe("age120", 512, 384, 1'b0, 1'b0, 24'd0);
    repeat (4) frame_tick();
    probe("age124", 512, 384, 1'b0, 1'b0, 24'd0);
    strobe(11'd512, 10'd384);
    frame_tick();
    check_eq("age125_stale", {31'd0, stale_o}, 32'd0);
    probe("age125", 512, 384, 1'b0, 1'b1, RED);

    // Blanked pixels never draw; a strobe during blank still commits
    probe("blank_hit", 512, 384, 1'b1, 1'b0, 24'd0);
    @(negedge clk_i); hcount_i = 11'd600; vcount_i = 10'd600; blank_i = 1'b1;
    strobe(11'd600, 10'd600);
    probe("blank_strobe", 600, 600, 1'b1, 1'b0, 24'd0);
    frame_tick();
    probe("blank_commit", 600, 600, 1'b0, 1'b1, RED);

    // Reset mid-frame while LIVE
    @(negedge clk_i); reset_i = 1'b1;
    @(posedge clk_i); #1;
    check_eq("mrst_px", {8'd0, pixel_o}, 32'd0);
    check_eq("mrst_on", {31'd0, marker_on_o}, 32'd0);
    check_eq("mrst_stale", {31'd0, stale_o}, 32'd0);
    @(negedge clk_i); reset_i = 1'b0;
    frame_tick();
    frame_tick();
    probe("mrst_600", 600, 600, 1'b0, 1'b0, 24'd0);
    probe("mrst_00", 0, 0, 1'b0, 1'b0, 24'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
